// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int CNT_W    = 10;

  // True when an hour/minute pair is a legal 24 h clock time
  function automatic logic time_valid(input logic [5:0] h, input logic [5:0] m);
    return (int'(h) <= HOUR_MAX) && (int'(m) <= MIN_MAX);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Signal bundle between the timekeeping/user side (master) and the alarm controller (slave).
interface alarm_controller_if;
  logic       tick_1hz;
  logic [5:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       alarm_on;
  logic       alarm_load;
  logic [5:0] alarm_hour_in;
  logic [5:0] alarm_minute_in;
  logic       snooze_btn;
  logic       stop_btn;
  logic [5:0] alarm_hour;
  logic [5:0] alarm_minute;
  logic       ringing;
  logic       buzzer;
  logic       snoozing;
  logic [1:0] state;

  modport master (
    output tick_1hz, hours, minutes, seconds, alarm_on, alarm_load,
           alarm_hour_in, alarm_minute_in, snooze_btn, stop_btn,
    input  alarm_hour, alarm_minute, ringing, buzzer, snoozing, state
  );

  modport slave (
    input  tick_1hz, hours, minutes, seconds, alarm_on, alarm_load,
           alarm_hour_in, alarm_minute_in, snooze_btn, stop_btn,
    output alarm_hour, alarm_minute, ringing, buzzer, snoozing, state
  );
endinterface

// File: rtl/alarm_match.sv
// Time-vs-alarm comparator with a one-shot trigger on the first matching clk.
module alarm_match
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] i_hours,
  input  logic [5:0] i_minutes,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_alarm_hour,
  input  logic [5:0] i_alarm_minute,
  output logic       o_trigger
);

  logic w_match;
  logic r_match_d;

  assign w_match = (i_hours == i_alarm_hour) && (i_minutes == i_alarm_minute) &&
                   (i_seconds == 6'd0);

  // Delayed match so that a whole second 0 yields a single trigger
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_match_d <= 1'b0;
    else        r_match_d <= w_match;
  end

  assign o_trigger = w_match && !r_match_d;

endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM: arm, ring, snooze and timeout around a stored alarm time.
// Optional snooze cap is built when ALARM_SNOOZE_LIMIT_EN is defined.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 9,
  parameter int RING_TIMEOUT_S = 60,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic               clk,
  input  logic               reset,
  alarm_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * 60);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);

  alarm_state_e     r_state;
  logic [5:0]       r_alarm_hour;
  logic [5:0]       r_alarm_minute;
  logic [CNT_W-1:0] r_ring_cnt;
  logic [CNT_W-1:0] r_snooze_cnt;
  logic             r_ringing;
  logic             r_buzzer;
  logic             r_snoozing;
  logic             w_trigger;
  logic             w_snooze_ok;
  logic             w_snooze_take;

  alarm_match u_match (
    .clk            (clk),
    .reset          (reset),
    .i_hours        (bus.hours),
    .i_minutes      (bus.minutes),
    .i_seconds      (bus.seconds),
    .i_alarm_hour   (r_alarm_hour),
    .i_alarm_minute (r_alarm_minute),
    .o_trigger      (w_trigger)
  );

  // Latch a new alarm time only when both fields are legal
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm_hour   <= '0;
      r_alarm_minute <= '0;
    end else if (bus.alarm_load && time_valid(bus.alarm_hour_in, bus.alarm_minute_in)) begin
      r_alarm_hour   <= bus.alarm_hour_in;
      r_alarm_minute <= bus.alarm_minute_in;
    end
  end

  // A snooze press is honoured only when nothing of higher priority is active
  assign w_snooze_take = (r_state == RINGING) && bus.alarm_on && !bus.alarm_load &&
                         !bus.stop_btn && bus.snooze_btn && w_snooze_ok;

`ifdef ALARM_SNOOZE_LIMIT_EN
  localparam int USED_W = (MAX_SNOOZES > 3) ? $clog2(MAX_SNOOZES + 1) : 2;
  logic [USED_W-1:0] r_snooze_used;

  // Snoozes taken since the alarm was last armed or disabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     r_snooze_used <= '0;
    else if (r_state == IDLE || r_state == ARMED)   r_snooze_used <= '0;
    else if (w_snooze_take)                         r_snooze_used <= r_snooze_used + USED_W'(1);
  end

  assign w_snooze_ok = (r_snooze_used != USED_W'(MAX_SNOOZES));
`else
  logic w_unused_max_snoozes;
  assign w_unused_max_snoozes = (MAX_SNOOZES != 0);
  assign w_snooze_ok = 1'b1;
`endif

  // Single-process FSM: state, counters and registered outputs change together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_ringing    <= 1'b0;
      r_buzzer     <= 1'b0;
      r_snoozing   <= 1'b0;
    end else if (!bus.alarm_on) begin
      r_state      <= IDLE;
      r_ring_cnt   <= '0;
      r_snooze_cnt <= '0;
      r_ringing    <= 1'b0;
      r_buzzer     <= 1'b0;
      r_snoozing   <= 1'b0;
    end else if (bus.alarm_load && (r_state == RINGING || r_state == SNOOZE)) begin
      r_state    <= ARMED;
      r_ringing  <= 1'b0;
      r_buzzer   <= 1'b0;
      r_snoozing <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= ARMED;
        ARMED: begin
          if (w_trigger) begin
            r_state    <= RINGING;
            r_ring_cnt <= '0;
            r_ringing  <= 1'b1;
            r_buzzer   <= 1'b1;
          end
        end
        RINGING: begin
          if (bus.stop_btn) begin
            r_state   <= ARMED;
            r_ringing <= 1'b0;
            r_buzzer  <= 1'b0;
          end else if (w_snooze_take) begin
            r_state      <= SNOOZE;
            r_snooze_cnt <= SNOOZE_LOAD;
            r_ringing    <= 1'b0;
            r_buzzer     <= 1'b0;
            r_snoozing   <= 1'b1;
          end else if (bus.tick_1hz) begin
            if (r_ring_cnt == RING_LAST) begin
              r_state   <= ARMED;
              r_ringing <= 1'b0;
              r_buzzer  <= 1'b0;
            end else begin
              r_ring_cnt <= r_ring_cnt + CNT_W'(1);
              r_buzzer   <= ~r_buzzer;
            end
          end
        end
        SNOOZE: begin
          if (bus.tick_1hz && r_snooze_cnt == CNT_W'(1)) begin
            r_state    <= RINGING;
            r_ring_cnt <= '0;
            r_ringing  <= 1'b1;
            r_buzzer   <= 1'b1;
            r_snoozing <= 1'b0;
          end else if (bus.stop_btn) begin
            r_state    <= ARMED;
            r_snoozing <= 1'b0;
          end else if (bus.tick_1hz) begin
            r_snooze_cnt <= r_snooze_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.alarm_hour   = r_alarm_hour;
  assign bus.alarm_minute = r_alarm_minute;
  assign bus.ringing      = r_ringing;
  assign bus.buzzer       = r_buzzer;
  assign bus.snoozing     = r_snoozing;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed scoreboard bench for alarm_controller (SNOOZE_MIN=1, RING_TIMEOUT_S=5, tick every 10 clk).
module tb_alarm_controller;
  import alarm_pkg::*;

  localparam int SNOOZE_MIN     = 1;
  localparam int RING_TIMEOUT_S = 5;
  localparam int MAX_SNOOZES    = 3;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  alarm_controller_if bus ();

  alarm_controller #(
    .SNOOZE_MIN     (SNOOZE_MIN),
    .RING_TIMEOUT_S (RING_TIMEOUT_S),
    .MAX_SNOOZES    (MAX_SNOOZES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       sb_q[$];
  int         err_cnt = 0;
  int         chk_cnt = 0;
  logic [5:0] exp_ah  = '0;
  logic [5:0] exp_am  = '0;
  int         t_h = 0, t_m = 0, t_s = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_time();
    bus.hours   = 6'(t_h);
    bus.minutes = 6'(t_m);
    bus.seconds = 6'(t_s);
  endtask

  task automatic advance_time();
    t_s++;
    if (t_s == 60) begin
      t_s = 0;
      t_m++;
      if (t_m == 60) begin
        t_m = 0;
        t_h = (t_h + 1) % 24;
      end
    end
    drive_time();
  endtask

  task automatic push(input string tag, input alarm_state_e st, input logic rg,
                      input logic bz, input logic sn);
    exp_t e;
    e.tag = tag;
    e.v   = {st, rg, bz, sn, exp_ah, exp_am};
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [16:0] obs;
    obs = {bus.state, bus.ringing, bus.buzzer, bus.snoozing, bus.alarm_hour, bus.alarm_minute};
    chk_cnt++;
    assert (sb_q.size() != 0) else begin
      err_cnt++;
      $error("FAIL scoreboard_empty: observed=%05h required=a queued expectation", obs);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      assert (obs === e.v) else begin
        err_cnt++;
        $error("FAIL %s: observed st=%0d ring=%b buzz=%b snz=%b alarm=%0d:%0d required st=%0d ring=%b buzz=%b snz=%b alarm=%0d:%0d",
               e.tag, obs[16:15], obs[14], obs[13], obs[12], obs[11:6], obs[5:0],
               e.v[16:15], e.v[14], e.v[13], e.v[12], e.v[11:6], e.v[5:0]);
      end
    end
  endtask

  task automatic clk_expect(input string tag, input alarm_state_e st, input logic rg,
                            input logic bz, input logic sn);
    push(tag, st, rg, bz, sn);
    step();
    check();
  endtask

  task automatic one_sec();
    repeat (9) step();
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    advance_time();
  endtask

  task automatic tick_expect(input string tag, input alarm_state_e st, input logic rg,
                             input logic bz, input logic sn);
    repeat (9) step();
    push(tag, st, rg, bz, sn);
    bus.tick_1hz = 1'b1;
    step();
    bus.tick_1hz = 1'b0;
    advance_time();
    check();
  endtask

  // Walk 07:29:59 -> 07:30:00 and expect ringing one clk after second 0 appears
  task automatic retrigger(input string tag);
    t_h = 7; t_m = 29; t_s = 59;
    drive_time();
    one_sec();
    clk_expect(tag, RINGING, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    reset               = 1'b0;
    bus.tick_1hz        = 1'b0;
    bus.alarm_on        = 1'b0;
    bus.alarm_load      = 1'b0;
    bus.alarm_hour_in   = '0;
    bus.alarm_minute_in = '0;
    bus.snooze_btn      = 1'b0;
    bus.stop_btn        = 1'b0;
    drive_time();

    // Reset values while reset is held
    #12;
    push("reset_state", IDLE, 1'b0, 1'b0, 1'b0);
    check();
    @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Load 07:30 while disarmed
    bus.alarm_load = 1'b1; bus.alarm_hour_in = 6'd7; bus.alarm_minute_in = 6'd30;
    exp_ah = 6'd7; exp_am = 6'd30;
    clk_expect("load_0730", IDLE, 1'b0, 1'b0, 1'b0);
    bus.alarm_load = 1'b0;

    // Arm
    bus.alarm_on = 1'b1;
    clk_expect("arm", ARMED, 1'b0, 1'b0, 1'b0);

    // Trigger then stop; rest of the minute must not re-trigger
    retrigger("trigger_0730");
    bus.stop_btn = 1'b1;
    clk_expect("stop", ARMED, 1'b0, 1'b0, 1'b0);
    bus.stop_btn = 1'b0;
    for (int i = 1; i <= 59; i++) tick_expect("no_retrigger", ARMED, 1'b0, 1'b0, 1'b0);

    // Snooze lasts exactly 60 ticks
    retrigger("trigger_for_snooze");
    bus.snooze_btn = 1'b1;
    clk_expect("snooze_enter", SNOOZE, 1'b0, 1'b0, 1'b1);
    bus.snooze_btn = 1'b0;
    for (int i = 1; i <= 59; i++) tick_expect("snooze_hold", SNOOZE, 1'b0, 1'b0, 1'b1);
    tick_expect("snooze_expire", RINGING, 1'b1, 1'b1, 1'b0);
    bus.stop_btn = 1'b1;
    clk_expect("stop_after_snooze", ARMED, 1'b0, 1'b0, 1'b0);
    bus.stop_btn = 1'b0;

    // Unattended ring: buzzer toggles each tick, auto-stop on the 5th
    retrigger("trigger_for_timeout");
    tick_expect("buzz_tick1", RINGING, 1'b1, 1'b0, 1'b0);
    tick_expect("buzz_tick2", RINGING, 1'b1, 1'b1, 1'b0);
    tick_expect("buzz_tick3", RINGING, 1'b1, 1'b0, 1'b0);
    tick_expect("buzz_tick4", RINGING, 1'b1, 1'b1, 1'b0);
    tick_expect("ring_timeout", ARMED, 1'b0, 1'b0, 1'b0);

    // Disarm while snoozing
    retrigger("trigger_for_disarm");
    bus.snooze_btn = 1'b1;
    clk_expect("snooze_before_disarm", SNOOZE, 1'b0, 1'b0, 1'b1);
    bus.snooze_btn = 1'b0;
    bus.alarm_on = 1'b0;
    clk_expect("disarm_in_snooze", IDLE, 1'b0, 1'b0, 1'b0);

    // Out-of-range load ignored, boundary 23:59 accepted, then restore 07:30
    bus.alarm_load = 1'b1; bus.alarm_hour_in = 6'd24; bus.alarm_minute_in = 6'd61;
    clk_expect("load_invalid", IDLE, 1'b0, 1'b0, 1'b0);
    bus.alarm_hour_in = 6'd23; bus.alarm_minute_in = 6'd59;
    exp_ah = 6'd23; exp_am = 6'd59;
    clk_expect("load_2359", IDLE, 1'b0, 1'b0, 1'b0);
    bus.alarm_hour_in = 6'd7; bus.alarm_minute_in = 6'd30;
    exp_ah = 6'd7; exp_am = 6'd30;
    clk_expect("load_restore", IDLE, 1'b0, 1'b0, 1'b0);
    bus.alarm_load = 1'b0;

    // Trigger coincident with arming is ignored
    t_h = 7; t_m = 29; t_s = 59;
    drive_time();
    step();
    t_s = 0; t_m = 30;
    drive_time();
    bus.alarm_on = 1'b1;
    clk_expect("arm_with_trigger", ARMED, 1'b0, 1'b0, 1'b0);
    clk_expect("no_late_trigger", ARMED, 1'b0, 1'b0, 1'b0);

    // Stop beats snooze in the same clk
    retrigger("trigger_for_both");
    bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
    clk_expect("stop_and_snooze", ARMED, 1'b0, 1'b0, 1'b0);
    bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;

    // Reload while ringing returns to ARMED
    retrigger("trigger_for_reload");
    bus.alarm_load = 1'b1;
    clk_expect("load_in_ringing", ARMED, 1'b0, 1'b0, 1'b0);
    bus.alarm_load = 1'b0;

    // Three snooze cycles, then a fourth press
    retrigger("trigger_for_cap");
    for (int k = 0; k < 3; k++) begin
      bus.snooze_btn = 1'b1;
      clk_expect("cap_snooze", SNOOZE, 1'b0, 1'b0, 1'b1);
      bus.snooze_btn = 1'b0;
      repeat (59) one_sec();
      tick_expect("cap_snooze_expire", RINGING, 1'b1, 1'b1, 1'b0);
    end
    bus.snooze_btn = 1'b1;
`ifdef ALARM_SNOOZE_LIMIT_EN
    clk_expect("snooze_capped", RINGING, 1'b1, 1'b1, 1'b0);
`else
    clk_expect("snooze_unlimited", SNOOZE, 1'b0, 1'b0, 1'b1);
`endif
    bus.snooze_btn = 1'b0;
    bus.stop_btn = 1'b1; bus.snooze_btn = 1'b1;
    clk_expect("final_stop", ARMED, 1'b0, 1'b0, 1'b0);
    bus.stop_btn = 1'b0; bus.snooze_btn = 1'b0;

    // Every queued expectation must have been consumed
    chk_cnt++;
    assert (sb_q.size() == 0) else begin
      err_cnt++;
      $error("FAIL scoreboard_drain: observed=%0d entries required=0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
